// File: rtl/nibble_serial_adder_ctrl_if.sv
// Command/result handshake bundle for the nibble-serial adder.
// Carries the optional ovf flag when NIBBLE_ADDER_OVF_EN is defined.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef NIBBLE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
`ifdef NIBBLE_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
`ifdef NIBBLE_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract computed on one 4-bit slice, one nibble per clock, LSB first.
// Define NIBBLE_ADDER_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDXW-1:0]  idx_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             accept_s;
  logic             last_s;
  logic [4:0]       nib_res_s;

  function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

`ifdef NIBBLE_ADDER_OVF_EN
  logic ovf_r;

  // Carry generated out of bit 2 of a slice, i.e. the carry into its top bit.
  function automatic logic msb_carry_in(input logic [3:0] x, input logic [3:0] y,
                                        input logic c);
    logic [3:0] t;
    t = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, c};
    return t[3];
  endfunction

  assign bus.ovf = ovf_r;
`endif

  assign accept_s  = (state_r == IDLE) && bus.in_valid;
  assign last_s    = (idx_r == IDXW'(NIB - 1));
  assign nib_res_s = nib_add(a_r[{idx_r, 2'b00} +: 4], b_r[{idx_r, 2'b00} +: 4], carry_r);

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

  // Next-state decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (bus.out_ready) state_nxt_s = IDLE;
        else               state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, handshake flags and the serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      // Flags decoded from the next state so they are flops, not logic on state_r.
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= bus.a;
            b_r     <= bus.op_sub ? ~bus.b : bus.b;
            carry_r <= bus.op_sub ? 1'b1 : bus.cin;
            idx_r   <= '0;
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= nib_res_s[3:0];
          carry_r                    <= nib_res_s[4];
          if (last_s) begin
            idx_r  <= '0;
            cout_r <= nib_res_s[4];
`ifdef NIBBLE_ADDER_OVF_EN
            ovf_r  <= nib_res_s[4] ^ msb_carry_in(a_r[{idx_r, 2'b00} +: 4],
                                                  b_r[{idx_r, 2'b00} +: 4], carry_r);
`endif
          end else begin
            idx_r <= idx_r + IDXW'(1'b1);
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
// Checks ovf as well when NIBBLE_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   lat;
  logic [WIDTH-1:0] held_sum;
  logic             held_cout;

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait for out_valid, check latency and the result (left in DONE).
  task automatic issue(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic c, input logic s,
                       input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    bus.a = av; bus.b = bv; bus.cin = c; bus.op_sub = s; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = ~c; bus.op_sub = ~s;
    check({tag, "_in_ready_run"}, {31'd0, bus.in_ready}, 32'd0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp_cout});
  endtask

  // Complete the result handshake and confirm return to IDLE.
  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_ov_after"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_ir_after"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.op_sub = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_sum", {16'd0, bus.sum}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef NIBBLE_ADDER_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_stays", {31'd0, bus.busy}, 32'd0);

    issue("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    drain("add");
    issue("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    drain("ripple");
    issue("cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
    drain("cin");
    issue("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    drain("sub_borrow");
    issue("sub_noborrow", 16'h0009, 16'h0002, 1'b0, 1'b1, 16'h0007, 1'b1);
    drain("sub_noborrow");

    // Backpressure: hold result, offer a new command that must be ignored
    issue("bp", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0);
    held_sum = bus.sum;
    held_cout = bus.cout;
    bus.a = 16'h1111; bus.b = 16'h2222; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_sum_stable", {16'd0, bus.sum}, {16'd0, 16'h0FFF});
      check("bp_cout_stable", {31'd0, bus.cout}, 32'd0);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("bp_busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.in_valid = 1'b0;
    drain("bp");
    check("bp_busy_idle", {31'd0, bus.busy}, 32'd0);
    check("bp_sum_kept", {16'd0, bus.sum}, {16'd0, held_sum});
    check("bp_cout_kept", {31'd0, bus.cout}, {31'd0, held_cout});
    tick();
    check("bp_not_queued", {31'd0, bus.busy}, 32'd0);

    // Reset after nibble 1 has been processed
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_sum", {16'd0, bus.sum}, 32'd0);
    check("mid_rst_cout", {31'd0, bus.cout}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    issue("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    drain("post_rst");

`ifdef NIBBLE_ADDER_OVF_EN
    issue("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    check("ovf_pos_flag", {31'd0, bus.ovf}, 32'd1);
    drain("ovf_pos");
    issue("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    check("ovf_neg_flag", {31'd0, bus.ovf}, 32'd1);
    drain("ovf_neg");
    issue("ovf_none", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    check("ovf_none_flag", {31'd0, bus.ovf}, 32'd0);
    drain("ovf_none");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds or subtracts WIDTH-bit operands on a single shared 4-bit ripple-carry adder slice, one nibble per clock, LSB nibble first.
- A registered carry links successive nibbles.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port).
- Trades latency for area versus a full-width adder.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4. NIB = WIDTH/4 is the nibble count.

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  command valid
- in_ready  output  1  block can accept a command
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- op_sub  input  1  1 = compute A - B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry-out (for subtract, 1 = no borrow)
- busy  output  1  high in RUN or DONE

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- States: IDLE, RUN, DONE. State is one-hot or binary; this is not observable at the ports.
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - Outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
  - Nibble index, carry register and operand registers clear to 0.
- IDLE:
  - in_ready=1.
  - On the clock edge where in_valid & in_ready:
    - Latch a into A_reg.
    - Latch b into B_reg, or ~b if op_sub=1.
    - Carry register = op_sub ? 1 : cin.
    - Index = 0; go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle the 4-bit adder takes A_reg[4i+3:4i], B_reg[4i+3:4i] and the carry register.
  - The nibble sum is written to sum[4i+3:4i]; the carry register takes the nibble carry-out; the index increments.
  - On the edge that processes nibble NIB-1: cout = final carry; go to DONE.
  - Index wraps to 0 on that edge and never exceeds NIB-1.
- DONE:
  - out_valid=1.
  - sum and cout held stable while out_ready=0, for any number of cycles.
  - On the edge with out_valid & out_ready: go to IDLE, out_valid=0.
  - sum and cout keep their last value until the next result overwrites them.
- Latency: out_valid rises exactly NIB clock edges after the accepting edge (4 for WIDTH=16).
- Throughput: one operation per NIB+2 cycles minimum. No overlap; in_ready is low from the accept edge until the result handshake edge.
- Sum during RUN is partial and is not valid.
- Inputs a, b, cin and op_sub may change freely after acceptance; only the latched copies are used.
- in_valid asserted during RUN/DONE is ignored and not queued; the requester must hold it until in_ready.
- Mid-operation reset aborts: the asynchronous clear applies immediately, and the first post-reset result comes from a fresh command only.
- WIDTH=4: RUN lasts one cycle.
- Arithmetic is modulo 2^WIDTH. In subtract mode cin is ignored and cout is the inverted borrow.

Optional Feature:
- Macro: NIBBLE_ADDER_OVF_EN.
- Defined:
  - Adds port ovf, output, 1 bit: signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured on the final RUN edge.
  - Reset 0; held in DONE like sum.
- Undefined: port ovf is absent; no extra logic.

Test Plan:
- Add (WIDTH=16): a=0x1234, b=0x4321, cin=0, op_sub=0 -> out_valid exactly 4 edges after accept; sum=0x5555, cout=0.
- Carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Subtract: a=0x0005, b=0x0007, op_sub=1, cin=1 -> sum=0xFFFE, cout=0. Then a=0x0009, b=0x0002 -> sum=0x0007, cout=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> sum and cout stable, in_ready=0, busy=1.
  - A new in_valid during DONE is ignored.
  - Release out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: deassert rst_n after nibble 1 -> all outputs 0 and in_ready=1 immediately. Then a=0x0001, b=0x0001 -> sum=0x0002.
- NIBBLE_ADDER_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, cout=0. Then a=0x8000, b=0x8000 -> sum=0x0000, ovf=1, cout=1.
